// File: rtl/video_timing_pkg.sv
// Shared encodings, colour-bar table, control payload and default 640x480@60 timing
// for video_timing_tx.
package video_timing_pkg;

    localparam int unsigned CNT_W = 16;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIX_W    = 24;
    localparam int unsigned DEF_MEM_LAT  = 1;

    typedef enum logic [1:0] {
        PAT_MEM   = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_SOLID = 2'd3
    } pat_sel_e;

    // {R,G,B} on/off per bar, left to right
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             act;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } vt_ctrl_t;

endpackage

// File: rtl/vt_delay_line.sv
// Fixed-latency shift register that keeps timing controls aligned with returning
// frame-buffer data.
module vt_delay_line #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] taps [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/video_timing_tx.sv
// Parametrised raster timing generator with frame-buffer read-ahead and output alignment.
// Optional test-pattern overlay is built when VTG_PATTERN_EN is defined.
module video_timing_tx
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_W    = DEF_PIX_W,
    parameter int unsigned MEM_LAT  = DEF_MEM_LAT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PIX_W-1:0] Mem_Data,
    input  logic             FrameSync,
    input  logic [1:0]       Pattern_Sel,
    output logic             Mem_Read,
    output logic [PIX_W-1:0] Out_pData,
    output logic             Out_pHSync,
    output logic             Out_pVSync,
    output logic             Out_pVDE,
    output logic [15:0]      DE_Line,
    output logic             Frame_Start,
    output logic [15:0]      Frame_Count
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt_c;
    logic [CNT_W-1:0] v_nxt_c;
    logic             frame_origin_c;
    vt_ctrl_t         ctrl_c;
    vt_ctrl_t         ctrl_out;
    logic [PIX_W-1:0] pix_c;

    // Raster position for the coming clock; decode works on this so stage 1 lines up with the counters
    always_comb begin
        h_nxt_c = (h_cnt == H_LAST) ? '0 : h_cnt + CNT_W'(1);
        v_nxt_c = v_cnt;
        if (h_cnt == H_LAST) begin
            v_nxt_c = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end
        frame_origin_c = (h_nxt_c == '0) && (v_nxt_c == '0);
    end

    always_comb begin
        ctrl_c.hs  = h_nxt_c < H_SYNC_END;
        ctrl_c.vs  = v_nxt_c < V_SYNC_END;
        ctrl_c.act = (h_nxt_c >= H_ACT_LO) && (h_nxt_c < H_ACT_HI) &&
                     (v_nxt_c >= V_ACT_LO) && (v_nxt_c < V_ACT_HI);
        ctrl_c.x   = h_nxt_c - H_ACT_LO;
        ctrl_c.y   = v_nxt_c - V_ACT_LO;
    end

    // Reset parks the counters on the last position so the first clock lands on (0,0)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            Mem_Read    <= 1'b0;
            Frame_Start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt_c;
            v_cnt       <= v_nxt_c;
            Mem_Read    <= ctrl_c.act;
            Frame_Start <= frame_origin_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Frame_Count <= '0;
        end else if (Frame_Start) begin
            Frame_Count <= Frame_Count + 16'(1);
        end
    end

    // MEM_LAT taps here plus the output register give MEM_LAT clocks between Mem_Read and DE
    vt_delay_line #(
        .W     ($bits(vt_ctrl_t)),
        .DEPTH (MEM_LAT)
    ) u_ctrl_dly (
        .clk   (clk),
        .rst_n (rstn),
        .d     (ctrl_c),
        .q     (ctrl_out)
    );

`ifdef VTG_PATTERN_EN
    localparam int unsigned CH_W  = PIX_W / 3;
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic             phase;
    logic [CNT_W-1:0] bar_q_c;
    logic [2:0]       bar_idx_c;
    logic [2:0]       bar_rgb_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= 1'b0;
        end else if (Frame_Start) begin
            phase <= FrameSync;
        end
    end

    always_comb begin
        bar_q_c   = ctrl_out.x / CNT_W'(BAR_W);
        bar_idx_c = (bar_q_c > CNT_W'(7)) ? 3'd7 : bar_q_c[2:0];
        bar_rgb_c = BAR_RGB[bar_idx_c];
        pix_c     = Mem_Data;
        case (pat_sel_e'(Pattern_Sel))
            PAT_CHECK: begin
                if ((ctrl_out.x[0] ^ ctrl_out.y[0]) == phase) begin
                    pix_c = '0;
                end
            end
            PAT_BARS: begin
                pix_c = PIX_W'({{CH_W{bar_rgb_c[2]}}, {CH_W{bar_rgb_c[1]}}, {CH_W{bar_rgb_c[0]}}});
            end
            PAT_SOLID: begin
                pix_c = '1;
            end
            default: begin
                pix_c = Mem_Data;
            end
        endcase
    end
`else
    logic unused_ok;

    assign pix_c     = Mem_Data;
    assign unused_ok = ^{Pattern_Sel, FrameSync, ctrl_out.x};
`endif

    // Sync, DE and pixel all leave through one register rank so they move on the same edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Out_pHSync <= ~HS_POL;
            Out_pVSync <= ~VS_POL;
            Out_pVDE   <= 1'b0;
            Out_pData  <= '0;
            DE_Line    <= '0;
        end else begin
            Out_pHSync <= ctrl_out.hs ? HS_POL : ~HS_POL;
            Out_pVSync <= ctrl_out.vs ? VS_POL : ~VS_POL;
            Out_pVDE   <= ctrl_out.act;
            Out_pData  <= ctrl_out.act ? pix_c : '0;
            if (ctrl_out.act) begin
                DE_Line <= ctrl_out.y;
            end
        end
    end

endmodule

// File: doc/video_timing_tx.md
Name: video_timing_tx

Overview:
- Parametrised successor of the fixed 640x480 HDMI transmit timing block.
- Generates HSync/VSync/DE for any raster from generic porch/sync parameters, with programmable sync polarity.
- Issues a frame-buffer read strobe ahead of DE by a configurable memory latency, so pixel data and DE are aligned.
- Sits between the frame-buffer read port and the TMDS/HDMI encoder; optional built-in test-pattern overlay.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSync width (lines)
- V_BP, 33, vertical back porch
- HS_POL, 0, HSync active level (0 = active-low)
- VS_POL, 0, VSync active level
- PIX_W, 24, pixel width (3 equal channels, must be divisible by 3)
- MEM_LAT, 1, clocks from Mem_Read to valid Mem_Data (1..4)

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- Mem_Data  in  PIX_W  pixel from frame buffer, valid MEM_LAT clocks after Mem_Read
- FrameSync  in  1  checker phase select, sampled at frame start
- Pattern_Sel  in  2  0 = memory, 1 = checker, 2 = colour bars, 3 = solid white
- Mem_Read  out  1  frame-buffer read strobe, one per active pixel
- Out_pData  out  PIX_W  pixel to encoder
- Out_pHSync  out  1  horizontal sync
- Out_pVSync  out  1  vertical sync
- Out_pVDE  out  1  data enable
- DE_Line  out  16  active line index, valid while Out_pVDE=1
- Frame_Start  out  1  one-clock pulse at h=0, v=0
- Frame_Count  out  16  frames since reset, wraps at 65535

Behaviour:
- Frame geometry:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP.
  - V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
  - Reset loads h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, so the first clock after reset is (0,0).
- Decode, registered at stage 1:
  - hs = h_cnt < H_SYNC.
  - vs = v_cnt < V_SYNC.
  - act = H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
- Mem_Read is stage-1 act: exactly H_ACTIVE contiguous pulses per active line and none in blanking.
- Alignment pipeline:
  - hs, vs, act, pixel x and line y are delayed a further MEM_LAT stages.
  - Out_pHSync, Out_pVSync, Out_pVDE and Out_pData all change on the same clock edge.
  - Total latency from counter to output = 1 + MEM_LAT clocks.
- Output levels: Out_pHSync = hs XNOR HS_POL inactive level, i.e. equals HS_POL while in sync; Out_pVSync likewise with VS_POL.
- Out_pData is 0 whenever Out_pVDE=0.
- Frame start:
  - Frame_Start pulses at stage 1 when counters are (0,0).
  - The checker phase register captures FrameSync on that pulse.
  - Frame_Count increments on that pulse.
- DE_Line = v_cnt - (V_SYNC+V_BP), pipelined with DE; it holds its last value during blanking.
- Reset mid-frame: all outputs return to their reset values immediately and the raster restarts at (0,0) on the first clock after release.
- Reset values of outputs:
  - Out_pHSync = ~HS_POL.
  - Out_pVSync = ~VS_POL.
  - Mem_Read, Out_pVDE, Out_pData, DE_Line, Frame_Start and Frame_Count = 0.
- Pattern_Sel is sampled per pixel; it is not synchronised.

Optional Feature:
- Macro VTG_PATTERN_EN.
- Defined:
  - Pattern_Sel 1: checker, pixel = 0 when (x[0]^y[0]) equals the checker phase, else Mem_Data.
  - Pattern_Sel 2: eight vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black), each channel all-ones or 0.
  - Pattern_Sel 3: all-ones.
  - Mem_Read still toggles in every mode.
- Not defined: Pattern_Sel and FrameSync are ignored and Out_pData = Mem_Data during DE.

Decomposition:
- Package video_timing_pkg holds:
  - Pattern_Sel encodings (PAT_MEM, PAT_CHECK, PAT_BARS, PAT_SOLID).
  - The 8-entry bar colour constant array.
  - The default 640x480@60 timing constants.
- One natural sub-module, vt_delay_line: a parametrised shift register of width W and depth MEM_LAT used to align control signals and the x/y indices.

Test Plan:
- Defaults, run 420000 clocks after reset -> Frame_Start at clock 1 and clock 420001; 480 DE lines of 640 pixels; HSync low for 96 clocks every 800; VSync low for 1600 clocks.
- MEM_LAT = 3, Mem_Data = counter incremented per Mem_Read -> first Out_pData of each line equals the value returned for the first Mem_Read of that line, DE rising exactly 3 clocks after Mem_Read rising.
- HS_POL = 1, VS_POL = 1 -> sync pulses active-high with identical widths; reset levels are 0.
- VTG_PATTERN_EN, Pattern_Sel = 1, FrameSync = 1 then 0 on alternate frames -> pixel (0,0) is 0 in one frame and Mem_Data in the next.
- VTG_PATTERN_EN, Pattern_Sel = 2 -> pixels 0..79 = FFFFFF, 80..159 = FFFF00, 560..639 = 000000.
- Assert rstn low at line 200, pixel 300 for 5 clocks -> all outputs at reset values; next Frame_Start exactly 1 clock after release; Frame_Count = 0 then 1.
